// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
//   state_e : divider phase (stopped, high phase, low phase)
//   MIN_DIV : smallest legal divide ratio; smaller requests are raised to it
//   hi_len  : high-phase length for ratio n (the odd cycle goes to high)
//   lo_len  : low-phase length for ratio n
package clk_div_pkg;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  localparam int unsigned MIN_DIV = 2;

  function automatic int unsigned hi_len(input int unsigned n);
    return n - (n / 2);
  endfunction

  function automatic int unsigned lo_len(input int unsigned n);
    return n / 2;
  endfunction

endpackage

// File: rtl/clk_div_cnt.sv
// Loadable down counter with terminal-count flag.
//   clk_in   : clock, rising edge
//   reset    : synchronous active-high reset, count -> 0
//   load     : load load_val this cycle (priority over counting)
//   load_val : value to load
//   tc       : high while the count is zero; the counter holds at zero
module clk_div_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == '0);

endmodule

// File: rtl/clk_div_prog.sv
// Programmable clock divider producing a registered divided clock.
// Optional feature macro: CLK_DIV_SYNC_EN adds the sync_in restart input.
//   clk_in   : sole clock, rising edge
//   reset    : synchronous active-high reset
//   en       : run request; a started period always completes
//   div_val  : requested divide ratio N (0 and 1 are raised to 2)
//   div_load : one-cycle strobe capturing div_val
//   sync_in  : (CLK_DIV_SYNC_EN only) restart the period while running
//   load_ack : one-cycle pulse in the first cycle a new ratio is active
//   clk_out  : divided clock, high for N-N/2 cycles, low for N/2 cycles
//   tick     : strobe in the first cycle of each clk_out high phase
//   running  : high while the divider is not stopped
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DEF_DIV = 32
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
`ifdef CLK_DIV_SYNC_EN
  input  logic             sync_in,
`endif
  output logic             load_ack,
  output logic             clk_out,
  output logic             tick,
  output logic             running
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             clk_out_q, tick_q, running_q, ack_q;
  logic             tick_d, ack_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_tc;

  logic             boundary, restart, apply_ratio;
  logic [CNT_W-1:0] ratio_next, div_clamped;

  clk_div_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk_in   (clk_in),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .tc       (cnt_tc)
  );

  assign div_clamped = (div_val < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : div_val;

  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    shadow_d    = shadow_q;
    pending_d   = pending_q;
    tick_d      = 1'b0;
    ack_d       = 1'b0;
    cnt_load    = 1'b0;
    cnt_val     = '0;
    restart     = 1'b0;
`ifdef CLK_DIV_SYNC_EN
    restart     = sync_in && (state_q != ST_STOP);
`endif
    // Last LOW cycle: the period ends whether or not another follows.
    boundary    = (state_q == ST_LOW) && cnt_tc;
    apply_ratio = pending_q && (boundary || restart);
    ratio_next  = apply_ratio ? shadow_q : active_q;

    if (apply_ratio) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
      ack_d     = 1'b1;
    end

    // Stopped: nothing to protect, so the new ratio takes effect at once.
    // Running: park it in the shadow; a strobe landing on the application
    // cycle waits for the following boundary.
    if (div_load) begin
      if (state_q == ST_STOP) begin
        active_d   = div_clamped;
        ratio_next = div_clamped;
        pending_d  = 1'b0;
        ack_d      = 1'b1;
      end else begin
        shadow_d  = div_clamped;
        pending_d = 1'b1;
      end
    end

    case (state_q)
      ST_STOP: begin
        if (en) begin
          state_d  = ST_HIGH;
          tick_d   = 1'b1;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(hi_len(32'(ratio_next)) - 1);
        end
      end
      ST_HIGH: begin
        if (cnt_tc) begin
          state_d  = ST_LOW;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(lo_len(32'(active_q)) - 1);
        end
      end
      ST_LOW: begin
        if (cnt_tc) begin
          cnt_load = 1'b1;
          if (en) begin
            state_d = ST_HIGH;
            tick_d  = 1'b1;
            cnt_val = CNT_W'(hi_len(32'(ratio_next)) - 1);
          end else begin
            state_d = ST_STOP;
          end
        end
      end
      default: begin
        state_d = ST_STOP;
      end
    endcase

    if (restart) begin
      state_d  = ST_HIGH;
      tick_d   = 1'b1;
      cnt_load = 1'b1;
      cnt_val  = CNT_W'(hi_len(32'(ratio_next)) - 1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q   <= ST_STOP;
      active_q  <= CNT_W'(DEF_DIV);
      shadow_q  <= '0;
      pending_q <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      clk_out_q <= (state_d == ST_HIGH);
      tick_q    <= tick_d;
      running_q <= (state_d != ST_STOP);
      ack_q     <= ack_d;
    end
  end

  assign clk_out  = clk_out_q;
  assign tick     = tick_q;
  assign running  = running_q;
  assign load_ack = ack_q;

endmodule
